rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one N:1 data multiplexer between N requesters.
- Decides which requester owns the mux and drives the registered mux select.
- Enforces a maximum hold time per grant and registers the selected data into a single valid-tagged output stage.
- Sits in front of any shared datapath resource (register-file write port, bus, shared ALU input).

---
 rtl/rr_mux_arbiter_if.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 140 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Interface bundling the requester bus and the arbitrated output bus of
// rr_mux_arbiter.
//   master : requester side; drives req/din and observes grant/output.
//   slave  : arbiter side; samples req/din and drives gnt/sel/out_*.
// Signals:
//   req       N     request vector, bit i = requester i has a word on din
//   din       N*W   packed data, requester i at [i*W +: W]
//   gnt       N     registered one-hot grant, zero when idle
//   sel       SW    registered mux select (index of current owner)
//   out_valid 1     registered, out_data holds a transferred word
//   out_data  W     registered selected data
//   out_src   SW    registered index of the requester behind out_data
interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;

  modport master (
    output req, din,
    input  gnt, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req, din,
    output gnt, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux between N requesters.
// Grants are held while the owner keeps requesting, but are rotated after
// MAX_HOLD consecutive cycles if anyone else is waiting. The selected word
// is registered into a single valid-tagged output stage.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  rr_mux_arbiter_if.slave (req/din in, gnt/sel/out_* out)
module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);
  localparam int SW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  cur_q, cur_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_src_q, out_src_d;

  logic [N-1:0]   cand;
  logic [SW-1:0]  nxt_ptr;
  logic [N-1:0]   pick_v;
  logic [SW-1:0]  pick_p;
  logic [SW-1:0]  pick_idx;
  logic           at_max;
  logic           release_c;

  // First set bit of v scanning p, p+1, ... with wrap. Scanning the offsets
  // from high to low lets the smallest offset win; N is a power of two so
  // SW-bit addition wraps naturally.
  function automatic logic [SW-1:0] pick(input logic [N-1:0] v,
                                         input logic [SW-1:0] p);
    logic [SW-1:0] idx;
    logic [SW-1:0] res;
    res = '0;
    for (int unsigned i = N; i > 0; i--) begin
      idx = p + SW'(i - 1);
      if (v[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    cand      = bus.req & ~(N'(1) << cur_q);
    nxt_ptr   = cur_q + SW'(1);
    at_max    = (hold_q == HW'(MAX_HOLD));
    release_c = !bus.req[cur_q] || (at_max && (cand != '0));

    // One shared scanner: from ptr over all requests when idle, from the
    // slot after the owner over the other requests when rotating.
    pick_v    = (state_q == IDLE) ? bus.req : cand;
    pick_p    = (state_q == IDLE) ? ptr_q : nxt_ptr;
    pick_idx  = pick(pick_v, pick_p);

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.req != '0) begin
          cur_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          hold_d  = HW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d = nxt_ptr;
          if (cand != '0) begin
            cur_d  = pick_idx;
            gnt_d  = N'(1) << pick_idx;
            hold_d = HW'(1);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (at_max) begin
          hold_d = HW'(1);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Output stage looks at the registered owner, giving 2-cycle latency.
    out_valid_d = (state_q == GRANT) && bus.req[cur_q];
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (out_valid_d) begin
      out_data_d = bus.din[cur_q*W +: W];
      out_src_d  = cur_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      gnt_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = cur_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(N), .W(W)) bus ();

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          ov;
    logic [W-1:0]  od;
    logic [SW-1:0] os;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: owner index, pointer, hold count as plain integers.
  bit   m_busy;
  int   m_cur, m_ptr, m_hold;
  logic          m_ov;
  logic [W-1:0]  m_od;
  int            m_os;

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq,
                            input logic [N*W-1:0] d);
    logic [N-1:0] others;
    bit rel;
    if (r) begin
      m_busy = 0; m_cur = 0; m_ptr = 0; m_hold = 0;
      m_ov = 0; m_od = '0; m_os = 0;
      return;
    end
    m_ov = m_busy && rq[m_cur];
    if (m_ov) begin
      m_od = d[m_cur*W +: W];
      m_os = m_cur;
    end
    if (!m_busy) begin
      if (rq != 0) begin
        m_cur = first_from(rq, m_ptr); m_hold = 1; m_busy = 1;
      end
    end else begin
      others = rq;
      others[m_cur] = 1'b0;
      rel = !rq[m_cur] || (m_hold == MH && others != 0);
      if (rel) begin
        m_ptr = (m_cur + 1) % N;
        if (others != 0) begin
          m_cur = first_from(others, (m_cur + 1) % N); m_hold = 1;
        end else begin
          m_busy = 0;
        end
      end else if (m_hold == MH) m_hold = 1;
      else m_hold = m_hold + 1;
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; bus.req = rq; bus.din = d;
    model_step(r, rq, d);
    e.gnt = m_busy ? (N'(1) << m_cur) : '0;
    e.sel = SW'(m_cur);
    e.ov  = m_ov;
    e.od  = m_od;
    e.os  = SW'(m_os);
    exp_q.push_back(e);
  endtask

  function automatic logic [N*W-1:0] rnd_din();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",       int'(bus.gnt),       int'(e.gnt));
        check("sel",       int'(bus.sel),       int'(e.sel));
        check("out_valid", int'(bus.out_valid), int'(e.ov));
        check("out_data",  int'(bus.out_data),  int'(e.od));
        check("out_src",   int'(bus.out_src),   int'(e.os));
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   rq;
    bus.req = '0;
    bus.din = '0;

    // Reset while everyone requests.
    cyc(1'b1, 4'b1111, rnd_din());
    cyc(1'b1, 4'b1111, rnd_din());
    cyc(1'b0, 4'b0000, '0);

    // Single requester with a fixed word.
    d = rnd_din();
    d[1*W +: W] = 8'hA5;
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0010, d);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, d);

    // Full contention with forced rotation.
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b1111, rnd_din());
    for (int i = 0; i < 2; i++)  cyc(1'b0, 4'b0000, '0);

    // Early release: owner 0 drops after two grant cycles.
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0101, rnd_din());
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, rnd_din());
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1111, rnd_din());
    cyc(1'b0, 4'b0000, '0);
    cyc(1'b0, 4'b0000, '0);

    // Lone long requester is never forced off.
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'b1000, rnd_din());
    cyc(1'b0, 4'b0000, '0);

    // Reset while requester 2 owns the mux.
    for (int i = 0; i < 16 && !(m_busy && m_cur == 2); i++)
      cyc(1'b0, 4'b1111, rnd_din());
    check("owner2_reached", int'(m_busy && m_cur == 2), 1);
    cyc(1'b1, 4'b1111, rnd_din());
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b1111, rnd_din());

    // Randomized requests with persistence and occasional resets.
    rq = '0;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      cyc(($urandom_range(63) == 0), rq, rnd_din());
    end
    cyc(1'b0, 4'b0000, '0);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
